// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the controller that drives it over the
// UART link. This package is used by both alu and alu_uart_ctrl.
//   - opcode constants for the eight supported operations
//   - controller state encoding (3-bit enum)
//   - bit positions inside the returned flag byte
//   - is_valid_op(): true when an opcode is one the ALU implements
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

   // Flag byte layout: {error, 5'b0, zero, overflow}
   localparam int FLG_OVF  = 0;
   localparam int FLG_ZERO = 1;
   localparam int FLG_ERR  = 7;

   typedef enum logic [2:0] {
      S_WAIT_A   = 3'd0,
      S_WAIT_B   = 3'd1,
      S_WAIT_OP  = 3'd2,
      S_EXEC     = 3'd3,
      S_TX_RES   = 3'd4,
      S_WAIT_RES = 3'd5,
      S_TX_FLG   = 3'd6,
      S_WAIT_FLG = 3'd7
   } state_t;

   // True for the eight opcodes the ALU implements; anything else is
   // reported back to the host as an error byte.
   function automatic logic is_valid_op(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_SRA, OP_SRL, OP_NOR: is_valid_op = 1'b1;
         default:                        is_valid_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_uart_ctrl.sv
// ---------------------------------------------------------------------------
// alu_uart_ctrl
// Byte-serial sequencer between the UART and the combinational ALU. Three
// received bytes (operand A, operand B, opcode) are latched onto the ALU
// ports; after one execute cycle the result and a flag byte are sent back
// through the UART transmitter, result first.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_rx_data/i_rx_valid  received byte and its one-cycle strobe
//   o_tx_data/o_tx_start  byte to transmit and its one-cycle request
//   i_tx_done             transmitter finished the current byte
//   o_data_a/o_data_b     ALU operands
//   o_operation_code      ALU opcode (low NB_OP bits of the third byte)
//   i_alu_result          ALU result
//   i_alu_overflow/zero   ALU flags
//   o_busy                high whenever not idle waiting for operand A
//   o_rx_drop             one-cycle pulse when a received byte is discarded
// ---------------------------------------------------------------------------
module alu_uart_ctrl
   import alu_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_valid,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_done,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_operation_code,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_alu_overflow,
   input  logic               i_alu_zero,
   output logic               o_busy,
   output logic               o_rx_drop
);

   state_t             state_q;
   state_t             state_d;
   logic [NB_DATA-1:0] result_q;
   logic [NB_DATA-1:0] flag_q;
   logic               tx_sel_flg_q;
   logic               op_ok;
   logic               rx_ignored;
   logic [NB_DATA-1:0] exec_result;
   logic [NB_DATA-1:0] exec_flags;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_WAIT_A;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. tx_done only matters in the two wait-for-transmit
   // states; a done arriving during a TX_* cycle is deliberately lost.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT_A:   if (i_rx_valid) state_d = S_WAIT_B;
         S_WAIT_B:   if (i_rx_valid) state_d = S_WAIT_OP;
         S_WAIT_OP:  if (i_rx_valid) state_d = S_EXEC;
         S_EXEC:     state_d = S_TX_RES;
         S_TX_RES:   state_d = S_WAIT_RES;
         S_WAIT_RES: if (i_tx_done) state_d = S_TX_FLG;
         S_TX_FLG:   state_d = S_WAIT_FLG;
         S_WAIT_FLG: if (i_tx_done) state_d = S_WAIT_A;
         default:    state_d = S_WAIT_A;
      endcase
   end

   // State-decoded outputs. The start strobe is one cycle wide because each
   // TX_* state always exits after a single cycle.
   always_comb begin
      o_tx_start = (state_q == S_TX_RES) || (state_q == S_TX_FLG);
      o_busy     = (state_q != S_WAIT_A);
   end

   // Values captured at the end of EXEC. An unknown opcode yields a zero
   // result and an error-only flag byte; the ALU flags are then meaningless
   // and are masked off.
   always_comb begin
      op_ok       = is_valid_op(o_operation_code);
      exec_result = op_ok ? i_alu_result : '0;
      exec_flags  = '0;
      exec_flags[FLG_ERR]  = ~op_ok;
      exec_flags[FLG_ZERO] = op_ok & i_alu_zero;
      exec_flags[FLG_OVF]  = op_ok & i_alu_overflow;
   end

   // Bytes arriving while the controller is executing or transmitting are
   // thrown away rather than queued.
   always_comb begin
      rx_ignored = i_rx_valid &&
                   (state_q != S_WAIT_A) &&
                   (state_q != S_WAIT_B) &&
                   (state_q != S_WAIT_OP);
   end

   // Datapath registers. Operands and opcode only move on the edge that
   // accepts their byte, so the ALU inputs are stable throughout EXEC.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_data_a         <= '0;
         o_data_b         <= '0;
         o_operation_code <= '0;
         result_q         <= '0;
         flag_q           <= '0;
         tx_sel_flg_q     <= 1'b0;
         o_rx_drop        <= 1'b0;
      end else begin
         if (i_rx_valid) begin
            case (state_q)
               S_WAIT_A:  o_data_a         <= i_rx_data;
               S_WAIT_B:  o_data_b         <= i_rx_data;
               S_WAIT_OP: o_operation_code <= i_rx_data[NB_OP-1:0];
               default:   ;
            endcase
         end
         if (state_q == S_EXEC) begin
            result_q     <= exec_result;
            flag_q       <= exec_flags;
            tx_sel_flg_q <= 1'b0;
         end
         if ((state_q == S_WAIT_RES) && i_tx_done) begin
            tx_sel_flg_q <= 1'b1;
         end
         o_rx_drop <= rx_ignored;
      end
   end

   // Transmit byte: both sources and the select are registers, and the
   // select only flips once the result byte has been fully sent, so the
   // byte is stable from start to done.
   always_comb begin
      o_tx_data = tx_sel_flg_q ? flag_q : result_q;
   end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_uart_ctrl
// Self-checking bench for alu_uart_ctrl. A small behavioural ALU sits beside
// the DUT, the way the real alu does on the board. Triples from a vector
// table are sent, and the two returned bytes and their timing are checked.
// Hand-written sequences cover reset, dropped bytes and mid-flight resets.
// ---------------------------------------------------------------------------
module tb_alu_uart_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_done;
   logic [7:0] data_a;
   logic [7:0] data_b;
   logic [5:0] op_code;
   logic [7:0] alu_result;
   logic       alu_overflow;
   logic       alu_zero;
   logic       busy;
   logic       rx_drop;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic [7:0] res;
      logic [7:0] flg;
   } vec_t;

   vec_t vecs[12];

   alu_uart_ctrl #(.NB_DATA(8), .NB_OP(6)) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_rx_data        (rx_data),
      .i_rx_valid       (rx_valid),
      .o_tx_data        (tx_data),
      .o_tx_start       (tx_start),
      .i_tx_done        (tx_done),
      .o_data_a         (data_a),
      .o_data_b         (data_b),
      .o_operation_code (op_code),
      .i_alu_result     (alu_result),
      .i_alu_overflow   (alu_overflow),
      .i_alu_zero       (alu_zero),
      .o_busy           (busy),
      .o_rx_drop        (rx_drop)
   );

   always #5 clk = ~clk;

   // Behavioural ALU. Unknown opcodes fall back to an add with real flags so
   // that the controller's masking of ALU flags on errors is exercised.
   always_comb begin
      alu_overflow = 1'b0;
      case (op_code)
         6'b100010: begin
            alu_result   = data_a - data_b;
            alu_overflow = (data_a[7] != data_b[7]) && (alu_result[7] != data_a[7]);
         end
         6'b100100: alu_result = data_a & data_b;
         6'b100101: alu_result = data_a | data_b;
         6'b100110: alu_result = data_a ^ data_b;
         6'b100111: alu_result = ~(data_a | data_b);
         6'b000011: alu_result = $signed(data_a) >>> data_b;
         6'b000010: alu_result = data_a >> data_b;
         default: begin
            alu_result   = data_a + data_b;
            alu_overflow = (data_a[7] == data_b[7]) && (alu_result[7] != data_a[7]);
         end
      endcase
      alu_zero = (alu_result == 8'h00);
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Presents one received byte for exactly one rising edge.
   task automatic applyStimulus(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic sendTriple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      applyStimulus(a);
      applyStimulus(b);
      applyStimulus(op);
   endtask

   // Entered 1 time unit after the edge that accepted the opcode byte.
   // Done is returned one cycle after each start (minimum turnaround).
   task automatic finishTx(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] res, input logic [7:0] flg);
      checkOutput({tag, " data_a"}, data_a, a);
      checkOutput({tag, " data_b"}, data_b, b);
      checkOutput({tag, " opcode"}, op_code, op[5:0]);
      checkOutput({tag, " exec start"}, tx_start, 1'b0);
      checkOutput({tag, " exec busy"}, busy, 1'b1);
      checkOutput({tag, " rx_drop idle"}, rx_drop, 1'b0);
      @(posedge clk);
      #1;
      checkOutput({tag, " res start"}, tx_start, 1'b1);
      checkOutput({tag, " res data"}, tx_data, res);
      @(posedge clk);
      #1;
      checkOutput({tag, " res start width"}, tx_start, 1'b0);
      checkOutput({tag, " res data hold"}, tx_data, res);
      tx_done = 1'b1;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      checkOutput({tag, " flg start"}, tx_start, 1'b1);
      checkOutput({tag, " flg data"}, tx_data, flg);
      @(posedge clk);
      #1;
      checkOutput({tag, " flg start width"}, tx_start, 1'b0);
      tx_done = 1'b1;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      checkOutput({tag, " idle busy"}, busy, 1'b0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " data_a"}, data_a, 8'h00);
      checkOutput({tag, " data_b"}, data_b, 8'h00);
      checkOutput({tag, " opcode"}, op_code, 6'h00);
      checkOutput({tag, " tx_data"}, tx_data, 8'h00);
      checkOutput({tag, " tx_start"}, tx_start, 1'b0);
      checkOutput({tag, " busy"}, busy, 1'b0);
      checkOutput({tag, " rx_drop"}, rx_drop, 1'b0);
   endtask

   task automatic pulseReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      //          a      b      op     res    flg
      vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 8'h00};  // ADD
      vecs[1]  = '{8'h7F, 8'h01, 8'h20, 8'h80, 8'h01};  // ADD overflow
      vecs[2]  = '{8'h05, 8'h05, 8'h22, 8'h00, 8'h02};  // SUB zero
      vecs[3]  = '{8'h05, 8'h03, 8'h3F, 8'h00, 8'h80};  // invalid
      vecs[4]  = '{8'hF0, 8'h0F, 8'h25, 8'hFF, 8'h00};  // OR after invalid
      vecs[5]  = '{8'hCC, 8'hAA, 8'h24, 8'h88, 8'h00};  // AND
      vecs[6]  = '{8'hFF, 8'hFF, 8'h26, 8'h00, 8'h02};  // XOR zero
      vecs[7]  = '{8'h00, 8'h00, 8'h27, 8'hFF, 8'h00};  // NOR
      vecs[8]  = '{8'h80, 8'h01, 8'h03, 8'hC0, 8'h00};  // SRA keeps sign
      vecs[9]  = '{8'h80, 8'h01, 8'h02, 8'h40, 8'h00};  // SRL
      vecs[10] = '{8'h80, 8'h01, 8'h22, 8'h7F, 8'h01};  // SUB overflow
      vecs[11] = '{8'h01, 8'h02, 8'hE0, 8'h03, 8'h00};  // upper opcode bits ignored -> ADD

      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_done  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkResetState("por");
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         sendTriple(vecs[i].a, vecs[i].b, vecs[i].op);
         finishTx($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                  vecs[i].res, vecs[i].flg);
      end

      // Invalid opcode whose fallback ALU output would overflow: the flags
      // must be masked to the error bit alone.
      sendTriple(8'h7F, 8'h01, 8'h21);
      finishTx("inv_ovf", 8'h7F, 8'h01, 8'h21, 8'h00, 8'h80);

      // Byte received while waiting for the result to finish transmitting.
      sendTriple(8'h05, 8'h03, 8'h20);
      @(posedge clk);
      #1;
      checkOutput("drop res start", tx_start, 1'b1);
      @(posedge clk);
      #1;
      rx_data  = 8'hAA;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      checkOutput("drop pulse", rx_drop, 1'b1);
      checkOutput("drop state hold", tx_start, 1'b0);
      checkOutput("drop data_a", data_a, 8'h05);
      checkOutput("drop tx_data", tx_data, 8'h08);
      @(posedge clk);
      #1;
      checkOutput("drop pulse width", rx_drop, 1'b0);
      checkOutput("drop busy", busy, 1'b1);
      tx_done = 1'b1;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      checkOutput("drop flg start", tx_start, 1'b1);
      checkOutput("drop flg data", tx_data, 8'h00);
      @(posedge clk);
      #1;
      tx_done = 1'b1;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      checkOutput("drop idle", busy, 1'b0);
      sendTriple(8'h02, 8'h03, 8'h20);
      finishTx("after_drop", 8'h02, 8'h03, 8'h20, 8'h05, 8'h00);

      // Reset while holding operand A in S_WAIT_B.
      applyStimulus(8'h11);
      checkOutput("rst_b busy", busy, 1'b1);
      checkOutput("rst_b data_a", data_a, 8'h11);
      pulseReset();
      checkResetState("rst_b");
      sendTriple(8'h10, 8'h20, 8'h20);
      finishTx("after_rst_b", 8'h10, 8'h20, 8'h20, 8'h30, 8'h00);

      // Reset while waiting for the flag byte to finish.
      sendTriple(8'h7F, 8'h01, 8'h20);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      tx_done = 1'b1;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      checkOutput("rst_flg flg data", tx_data, 8'h01);
      @(posedge clk);
      #1;
      checkOutput("rst_flg busy before", busy, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkResetState("rst_flg");
      sendTriple(8'h05, 8'h05, 8'h22);
      finishTx("after_rst_flg", 8'h05, 8'h05, 8'h22, 8'h00, 8'h02);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_uart_ctrl.md
# alu_uart_ctrl

Byte-serial controller that sequences the combinational ALU from a UART link. It collects three received bytes in order (operand A, operand B, opcode) and drives them onto the ALU ports. It then captures the result and flags and returns two bytes to the UART transmitter: the result byte, then the flag byte. It sits between `uart_rx`/`uart_tx` and `alu` in the board top level.

## Interface
Parameters:
- `NB_DATA`, 8: operand, result and UART byte width.
- `NB_OP`, 6: opcode width; the opcode is taken from the low `NB_OP` bits of the third byte.

Ports:
- `i_clk`  in  1  system clock; the only clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  NB_DATA  received byte; valid only while `i_rx_valid` is high.
- `i_rx_valid`  in  1  one-cycle pulse per received byte.
- `o_tx_data`  out  NB_DATA  byte to transmit; held stable from `o_tx_start` until `i_tx_done`.
- `o_tx_start`  out  1  one-cycle transmit request.
- `i_tx_done`  in  1  one-cycle pulse when the transmitter finishes a byte.
- `o_data_a`, `o_data_b`  out  NB_DATA  ALU operands (signed).
- `o_operation_code`  out  NB_OP  ALU opcode.
- `i_alu_result`  in  NB_DATA  ALU result.
- `i_alu_overflow`, `i_alu_zero`  in  1  ALU flags.
- `o_busy`  out  1  high in every state except `S_WAIT_A`.
- `o_rx_drop`  out  1  one-cycle pulse when a received byte is discarded.

## Operation
- The FSM has eight states: `S_WAIT_A`, `S_WAIT_B`, `S_WAIT_OP`, `S_EXEC`, `S_TX_RES`, `S_WAIT_RES`, `S_TX_FLG`, `S_WAIT_FLG`.
- Byte collection:
  - `S_WAIT_A` + `i_rx_valid`: register `o_data_a`, go to `S_WAIT_B`.
  - `S_WAIT_B` + `i_rx_valid`: register `o_data_b`, go to `S_WAIT_OP`.
  - `S_WAIT_OP` + `i_rx_valid`: register `o_operation_code` from `i_rx_data[NB_OP-1:0]`; the upper bits are ignored. Go to `S_EXEC`.
- Execute:
  - `S_EXEC` lasts exactly one cycle.
  - At its end, capture `i_alu_result` into the result register.
  - Capture the flag byte as {error, 5'b0, zero, overflow}, i.e. bit7 = error, bit1 = zero, bit0 = overflow.
- Opcode check:
  - Valid opcodes are ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
  - Any other opcode: the result register is forced to 0x00 and the flag byte to 0x80. ALU flags are ignored.
- Transmit:
  - `S_TX_RES`: assert `o_tx_start` for one cycle with `o_tx_data` = result, then go to `S_WAIT_RES`.
  - `S_WAIT_RES` + `i_tx_done`: go to `S_TX_FLG`.
  - `S_TX_FLG`: assert `o_tx_start` for one cycle with `o_tx_data` = flag byte, then go to `S_WAIT_FLG`.
  - `S_WAIT_FLG` + `i_tx_done`: go to `S_WAIT_A`.
- Dropped bytes: `i_rx_valid` in `S_EXEC`, `S_TX_*` or `S_WAIT_*` transmit states discards the byte and pulses `o_rx_drop` in the next cycle. State and registers are unaffected.
- `i_tx_done` is ignored in all states except `S_WAIT_RES` and `S_WAIT_FLG`. This includes the `S_TX_*` cycle itself, so a same-cycle done is lost and must not occur.
- No timeouts. A partially received triple waits indefinitely.

## Timing
- Reset takes effect on the first rising edge with `i_reset` high, from any state including mid-transmit. It sets:
  - state `S_WAIT_A`;
  - `o_data_a`, `o_data_b`, `o_operation_code`, `o_tx_data` = 0;
  - `o_tx_start`, `o_busy`, `o_rx_drop` = 0;
  - result and flag registers = 0.
- Operand and opcode outputs change only on the edge that accepts their byte, and otherwise hold their last value. The ALU therefore sees stable inputs for the whole of `S_EXEC`.
- Latency:
  - Opcode byte accepted at edge N: `S_EXEC` is the cycle after N.
  - `o_tx_start` (result byte) is high in the cycle after edge N+1.
  - Flag-byte `o_tx_start` is high in the cycle after the edge that samples the first `i_tx_done`.
- `o_tx_start` is never high for two consecutive cycles.
- `o_tx_data` is registered and valid in the same cycle as `o_tx_start`.
- Minimum turnaround: with `i_tx_done` asserted one cycle after each start, a new operand A is accepted 6 cycles after the opcode byte.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (the eight codes above);
  - state encoding (3-bit enum);
  - flag-byte bit positions (`FLG_OVF`=0, `FLG_ZERO`=1, `FLG_ERR`=7).
- `alu` imports the same opcode constants.
- Single module, no sub-module. The opcode-valid check is a function in `alu_pkg`.
- `alu` is instantiated beside this block in the top level, not inside it.

## Test plan
- Rx 0x05, 0x03, 0x20 (ADD) -> tx 0x08, then 0x00; `o_tx_start` 2 cycles after the opcode edge.
- Rx 0x7F, 0x01, 0x20 -> tx 0x80, then flags 0x01 (overflow).
- Rx 0x05, 0x05, 0x22 (SUB) -> tx 0x00, then flags 0x02 (zero).
- Rx 0x05, 0x03, 0x3F (invalid) -> tx 0x00, then 0x80. Then rx 0xF0, 0x0F, 0x25 (OR) -> tx 0xFF, 0x00.
- `i_rx_valid` (0xAA) during `S_WAIT_RES` -> `o_rx_drop` pulses once, tx sequence unchanged, and the next accepted byte is operand A.
- `i_reset` asserted in `S_WAIT_B` and in `S_WAIT_FLG` -> all outputs 0 next cycle, `o_busy`=0, and a new 3-byte triple executes correctly.
